// File: rtl/matrix_scan_bcm_pkg.sv
// Purpose: shared types and plane-selection helpers for the HUB75 BCM scan controller.
// Contents: FSM state enum, plane index width, next-enabled-plane functions.
package matrix_scan_bcm_pkg;

    // Upper bound on bit-planes the helpers can walk; enables are zero-extended to this.
    localparam int unsigned MAX_BB  = 32;
    localparam int unsigned PLANE_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CLKH,
        S_CLKL,
        S_BLANK,
        S_LATCH,
        S_SHOW
    } state_e;

    // Result of stepping to the next enabled plane; wrapped means the row is finished.
    typedef struct packed {
        logic               wrapped;
        logic [PLANE_W-1:0] idx;
    } plane_sel_t;

    // Lowest set bit of the enable vector (0 when nothing is enabled).
    function automatic logic [PLANE_W-1:0] lowest_plane(input logic [MAX_BB-1:0] en);
        logic [PLANE_W-1:0] idx;
        idx = '0;
        for (int i = int'(MAX_BB) - 1; i >= 0; i--) begin
            if (en[i]) idx = PLANE_W'(i);
        end
        return idx;
    endfunction

    // Next higher enabled plane above cur, else wrap to the lowest enabled plane.
    function automatic plane_sel_t next_plane(input logic [MAX_BB-1:0] en,
                                              input logic [PLANE_W-1:0] cur);
        plane_sel_t sel;
        sel.wrapped = 1'b1;
        sel.idx     = lowest_plane(en);
        for (int i = int'(MAX_BB) - 1; i >= 0; i--) begin
            if (en[i] && (PLANE_W'(i) > cur)) begin
                sel.wrapped = 1'b0;
                sel.idx     = PLANE_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/matrix_scan_bcm_if.sv
// Purpose: fetch handshake + panel pin bundle between the scan controller and its neighbours.
// master: scan controller (drives request/address/panel pins, receives pixel_valid/enables).
// slave : fetch/panel side.
interface matrix_scan_bcm_if #(
    parameter int unsigned COL_W = 6,
    parameter int unsigned ROW_W = 4,
    parameter int unsigned BB    = 6
);
    logic             pixel_valid;
    logic [BB-1:0]    brightness_enable;
    logic             pixel_req;
    logic [COL_W-1:0] column_address;
    logic [ROW_W-1:0] row_address;
    logic [ROW_W-1:0] row_address_active;
    logic [BB-1:0]    brightness_mask;
    logic             clk_pixel;
    logic             row_latch;
    logic             output_enable;
    logic             frame_start;

    modport master (
        input  pixel_valid, brightness_enable,
        output pixel_req, column_address, row_address, row_address_active,
               brightness_mask, clk_pixel, row_latch, output_enable, frame_start
    );

    modport slave (
        output pixel_valid, brightness_enable,
        input  pixel_req, column_address, row_address, row_address_active,
               brightness_mask, clk_pixel, row_latch, output_enable, frame_start
    );
endinterface

// File: rtl/matrix_scan_bcm_bcm_timer.sv
// Purpose: loadable down-counter timing both the blanking gap and the BCM show window.
// Ports: clk_in/reset (sync, active-high); load/load_val preset the count; dec counts down
//        toward 1; done_c is high while the count sits at 1 (last cycle of the window).
module matrix_scan_bcm_bcm_timer #(
    parameter int unsigned SHOW_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic [SHOW_W-1:0] load_val,
    output logic              done_c
);
    logic [SHOW_W-1:0] count_q;
    logic [SHOW_W-1:0] count_d;

    // Next count: load wins, otherwise count down and park at 1.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q > SHOW_W'(1))) begin
            count_d = count_q - SHOW_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign done_c = (count_q == SHOW_W'(1));
endmodule

// File: rtl/matrix_scan_bcm.sv
// Purpose: HUB75 row scan controller with binary-code-modulated output-enable timing.
//   Per row and enabled plane: fetch+shift COLUMNS pixels, blank, latch, show BASE_CYCLES<<plane.
// Ports: clk_in, reset (sync, active-high); bus (master modport): pixel_req/pixel_valid fetch
//   handshake with column/row address and plane mask, panel pins clk_pixel/row_latch/
//   output_enable/row_address_active, brightness_enable plane enables, frame_start pulse.
module matrix_scan_bcm
    import matrix_scan_bcm_pkg::*;
#(
    parameter int unsigned COLUMNS         = 64,
    parameter int unsigned COL_W           = 6,
    parameter int unsigned ROW_W           = 4,
    parameter int unsigned BRIGHTNESS_BITS = 6,
    parameter int unsigned BASE_CYCLES     = 4,
    parameter int unsigned BLANK_CYCLES    = 2,
    parameter int unsigned SHOW_W          = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    matrix_scan_bcm_if.master bus
);
    localparam int unsigned BB = BRIGHTNESS_BITS;

    state_e             state_q, state_d;
    logic               pixel_req_q, pixel_req_d;
    logic               clk_pixel_q, clk_pixel_d;
    logic               row_latch_q, row_latch_d;
    logic               output_enable_q, output_enable_d;
    logic               frame_start_q, frame_start_d;
    logic [COL_W-1:0]   column_address_q, column_address_d;
    logic [ROW_W-1:0]   row_address_q, row_address_d;
    logic [ROW_W-1:0]   row_address_active_q, row_address_active_d;
    logic [BB-1:0]      brightness_mask_q, brightness_mask_d;
    logic [PLANE_W-1:0] plane_q, plane_d;

    logic [MAX_BB-1:0]  enable_c;
    logic [PLANE_W-1:0] lowest_c;
    plane_sel_t         next_c;
    logic [ROW_W-1:0]   row_next_c;
    logic               timer_load_c;
    logic               timer_dec_c;
    logic [SHOW_W-1:0]  timer_val_c;
    logic               timer_done_c;

    assign enable_c    = MAX_BB'(bus.brightness_enable);
    assign lowest_c    = lowest_plane(enable_c);
    assign next_c      = next_plane(enable_c, plane_q);
    assign row_next_c  = next_c.wrapped ? (row_address_q + ROW_W'(1)) : row_address_q;
    assign timer_dec_c = (state_q == S_BLANK) || (state_q == S_SHOW);

    matrix_scan_bcm_bcm_timer #(.SHOW_W(SHOW_W)) u_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (timer_load_c),
        .dec      (timer_dec_c),
        .load_val (timer_val_c),
        .done_c   (timer_done_c)
    );

    // Next-state and next-output logic; outputs are set on entry to the state that owns them.
    always_comb begin
        state_d              = state_q;
        pixel_req_d          = pixel_req_q;
        clk_pixel_d          = clk_pixel_q;
        row_latch_d          = row_latch_q;
        output_enable_d      = output_enable_q;
        frame_start_d        = 1'b0;
        column_address_d     = column_address_q;
        row_address_d        = row_address_q;
        row_address_active_d = row_address_active_q;
        brightness_mask_d    = brightness_mask_q;
        plane_d              = plane_q;
        timer_load_c         = 1'b0;
        timer_val_c          = '0;

        case (state_q)
            S_IDLE: begin
                output_enable_d = 1'b0;
                if (enable_c != '0) begin
                    state_d           = S_REQ;
                    pixel_req_d       = 1'b1;
                    plane_d           = lowest_c;
                    brightness_mask_d = BB'(1) << lowest_c;
                    column_address_d  = '0;
                    frame_start_d     = (row_address_q == '0);
                end
            end
            S_REQ: begin
                if (bus.pixel_valid) begin
                    state_d     = S_CLKH;
                    pixel_req_d = 1'b0;
                    clk_pixel_d = 1'b1;
                end
            end
            S_CLKH: begin
                state_d     = S_CLKL;
                clk_pixel_d = 1'b0;
            end
            S_CLKL: begin
                if (column_address_q == COL_W'(COLUMNS - 1)) begin
                    state_d          = S_BLANK;
                    column_address_d = '0;
                    timer_load_c     = 1'b1;
                    timer_val_c      = SHOW_W'(BLANK_CYCLES);
                end else begin
                    state_d          = S_REQ;
                    column_address_d = column_address_q + COL_W'(1);
                    pixel_req_d      = 1'b1;
                end
            end
            S_BLANK: begin
                if (timer_done_c) begin
                    state_d              = S_LATCH;
                    row_latch_d          = 1'b1;
                    row_address_active_d = row_address_q;
                    timer_load_c         = 1'b1;
                    timer_val_c          = SHOW_W'(BASE_CYCLES) << plane_q;
                end
            end
            S_LATCH: begin
                state_d         = S_SHOW;
                row_latch_d     = 1'b0;
                output_enable_d = 1'b1;
            end
            S_SHOW: begin
                // Enables are only looked at here, so a mid-plane change waits for this edge.
                if (timer_done_c) begin
                    output_enable_d = 1'b0;
                    if (enable_c == '0) begin
                        state_d           = S_IDLE;
                        brightness_mask_d = '0;
                    end else begin
                        state_d           = S_REQ;
                        pixel_req_d       = 1'b1;
                        plane_d           = next_c.idx;
                        brightness_mask_d = BB'(1) << next_c.idx;
                        row_address_d     = row_next_c;
                        frame_start_d     = (row_next_c == '0) && (next_c.idx == lowest_c);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q              <= S_IDLE;
            pixel_req_q          <= 1'b0;
            clk_pixel_q          <= 1'b0;
            row_latch_q          <= 1'b0;
            output_enable_q      <= 1'b0;
            frame_start_q        <= 1'b0;
            column_address_q     <= '0;
            row_address_q        <= '0;
            row_address_active_q <= '0;
            brightness_mask_q    <= '0;
            plane_q              <= lowest_c;
        end else begin
            state_q              <= state_d;
            pixel_req_q          <= pixel_req_d;
            clk_pixel_q          <= clk_pixel_d;
            row_latch_q          <= row_latch_d;
            output_enable_q      <= output_enable_d;
            frame_start_q        <= frame_start_d;
            column_address_q     <= column_address_d;
            row_address_q        <= row_address_d;
            row_address_active_q <= row_address_active_d;
            brightness_mask_q    <= brightness_mask_d;
            plane_q              <= plane_d;
        end
    end

    assign bus.pixel_req          = pixel_req_q;
    assign bus.clk_pixel          = clk_pixel_q;
    assign bus.row_latch          = row_latch_q;
    assign bus.output_enable      = output_enable_q;
    assign bus.frame_start        = frame_start_q;
    assign bus.column_address     = column_address_q;
    assign bus.row_address        = row_address_q;
    assign bus.row_address_active = row_address_active_q;
    assign bus.brightness_mask    = brightness_mask_q;
endmodule
